// File: rtl/pending_req_encoder_pkg.sv
// Shared types for the pending-request encoder: FSM state encoding and the
// default request-line count.
package pending_req_encoder_pkg;

   localparam int unsigned DEFAULT_REQUESTS = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

endpackage : pending_req_encoder_pkg

// File: rtl/pending_req_encoder_if.sv
// Request/offer bundle between event sources, the encoder and its consumer.
// The slave side is the encoder; the master side drives requests and ready.
interface pending_req_encoder_if
   import pending_req_encoder_pkg::*;
#(
   parameter int unsigned no_of_requests = DEFAULT_REQUESTS
);

   localparam int unsigned IDX_W = $clog2(no_of_requests);
   localparam int unsigned CNT_W = $clog2(no_of_requests + 1);

   logic [no_of_requests-1:0] req;
   logic                      out_ready;
   logic                      out_valid;
   logic [IDX_W-1:0]          out_idx;
   logic [no_of_requests-1:0] out_onehot;
   logic [CNT_W-1:0]          pend_count;

   modport master (
      output req,
      output out_ready,
      input  out_valid,
      input  out_idx,
      input  out_onehot,
      input  pend_count
   );

   modport slave (
      input  req,
      input  out_ready,
      output out_valid,
      output out_idx,
      output out_onehot,
      output pend_count
   );

endinterface : pending_req_encoder_if

// File: rtl/pending_req_encoder_prio_enc_lowest.sv
// Combinational lowest-set-bit encoder: idx of the lowest 1 in x, any = |x.
// idx is 0 when x is empty.
module prio_enc_lowest #(
   parameter  int unsigned no_of_requests = 32,
   localparam int unsigned IDX_W          = $clog2(no_of_requests)
) (
   input  logic [no_of_requests-1:0] x,
   output logic [IDX_W-1:0]          idx,
   output logic                      any
);

   // Scan high to low so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      for (int unsigned i = no_of_requests; i > 0; i--) begin
         if (x[i-1]) begin
            idx = IDX_W'(i - 1);
         end
      end
      any = |x;
   end

endmodule : prio_enc_lowest

// File: rtl/pending_req_encoder.sv
// Sticky-latching priority encoder: collects request pulses into pending[]
// and offers the lowest pending index over a valid/ready handshake.
module pending_req_encoder
   import pending_req_encoder_pkg::*;
#(
   parameter int unsigned no_of_requests = DEFAULT_REQUESTS
) (
   input logic                   clk,
   input logic                   async_reset,
   pending_req_encoder_if.slave  bus
);

   localparam int unsigned IDX_W = $clog2(no_of_requests);
   localparam int unsigned CNT_W = $clog2(no_of_requests + 1);
   localparam logic [no_of_requests-1:0] ONE = no_of_requests'(1);

   state_t                    state, state_next;
   logic [no_of_requests-1:0] pending, pending_next;
   logic [IDX_W-1:0]          out_idx, idx_next;
   logic [no_of_requests-1:0] out_onehot, onehot_next;
   logic [CNT_W-1:0]          pend_count, count_next;

   logic                      hs;
   logic [no_of_requests-1:0] offered;
   logic [no_of_requests-1:0] clr;
   logic [no_of_requests-1:0] cand;
   logic [IDX_W-1:0]          low_pend, low_cand;
   logic                      any_pend, any_cand;

   function automatic logic [CNT_W-1:0] popcount(input logic [no_of_requests-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int unsigned i = 0; i < no_of_requests; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

   prio_enc_lowest #(.no_of_requests(no_of_requests)) u_enc_pend (
      .x   (pending),
      .idx (low_pend),
      .any (any_pend)
   );

   prio_enc_lowest #(.no_of_requests(no_of_requests)) u_enc_cand (
      .x   (cand),
      .idx (low_cand),
      .any (any_cand)
   );

   // Selection looks only at registered pending; same-cycle req is merged
   // into pending_next but never competes for the slot in this cycle.
   always_comb begin
      state_next   = state;
      idx_next     = out_idx;
      onehot_next  = out_onehot;
      hs           = (state == OFFER) && bus.out_ready;
      offered      = ONE << out_idx;
      clr          = hs ? offered : '0;
      pending_next = (pending & ~clr) | bus.req;
      cand         = pending & ~offered;
      count_next   = popcount(pending_next);

      case (state)
         IDLE: begin
            if (any_pend) begin
               state_next  = OFFER;
               idx_next    = low_pend;
               onehot_next = ONE << low_pend;
            end
         end
         OFFER: begin
            if (hs) begin
               if (any_cand) begin
                  idx_next    = low_cand;
                  onehot_next = ONE << low_cand;
               end else begin
                  state_next  = IDLE;
                  onehot_next = '0;
               end
            end
         end
         default: begin
            state_next  = IDLE;
            onehot_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge async_reset) begin
      if (!async_reset) begin
         state      <= IDLE;
         pending    <= '0;
         out_idx    <= '0;
         out_onehot <= '0;
         pend_count <= '0;
      end else begin
         state      <= state_next;
         pending    <= pending_next;
         out_idx    <= idx_next;
         out_onehot <= onehot_next;
         pend_count <= count_next;
      end
   end

   assign bus.out_valid  = (state == OFFER);
   assign bus.out_idx    = out_idx;
   assign bus.out_onehot = out_onehot;
   assign bus.pend_count = pend_count;

endmodule : pending_req_encoder

// File: tb/tb_pending_req_encoder.sv
// Directed bench for pending_req_encoder (N=32): vector table plus hand-written
// sequences for re-request and asynchronous reset mid-offer.
module tb_pending_req_encoder;

   localparam int unsigned N = 32;

   typedef struct {
      logic [31:0] req;
      logic        rdy;
      logic        valid;
      logic [4:0]  idx;
      logic [31:0] onehot;
      logic [5:0]  count;
   } vec_t;

   logic clk = 1'b0;
   logic async_reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];

   pending_req_encoder_if #(.no_of_requests(N)) bus ();

   pending_req_encoder #(.no_of_requests(N)) dut (
      .clk         (clk),
      .async_reset (async_reset),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [31:0] req, input logic rdy, input logic valid,
                               input logic [4:0] idx, input logic [31:0] onehot,
                               input logic [5:0] count);
      vec_t v;
      v.req = req; v.rdy = rdy; v.valid = valid;
      v.idx = idx; v.onehot = onehot; v.count = count;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag, input logic valid, input logic [4:0] idx,
                                input logic [31:0] onehot, input logic [5:0] count,
                                input logic check_idx);
      check({tag, ".valid"}, 32'(bus.out_valid), 32'(valid));
      if (check_idx) check({tag, ".idx"}, 32'(bus.out_idx), 32'(idx));
      check({tag, ".onehot"}, bus.out_onehot, onehot);
      check({tag, ".count"}, 32'(bus.pend_count), 32'(count));
   endtask

   // Drive inputs at the falling edge, sample 1ns after the following rising edge.
   task automatic step(input logic [31:0] req, input logic rdy);
      @(negedge clk);
      bus.req       = req;
      bus.out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.req       = '0;
      bus.out_ready = 1'b0;

      // Two requests held unacknowledged, then drained lowest-first.
      vecs.push_back(mk(32'h0000_0014, 1'b0, 1'b0, 5'd0, 32'h0, 6'd2));
      for (int i = 0; i < 10; i++)
         vecs.push_back(mk(32'h0, 1'b0, 1'b1, 5'd2, 32'h4, 6'd2));
      vecs.push_back(mk(32'h0, 1'b1, 1'b1, 5'd4, 32'h10, 6'd1));
      vecs.push_back(mk(32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 6'd0));
      vecs.push_back(mk(32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 6'd0));
      // Lower-index request arriving mid-offer does not preempt.
      vecs.push_back(mk(32'h0000_0020, 1'b0, 1'b0, 5'd0, 32'h0, 6'd1));
      vecs.push_back(mk(32'h0, 1'b0, 1'b1, 5'd5, 32'h20, 6'd1));
      vecs.push_back(mk(32'h0000_0002, 1'b0, 1'b1, 5'd5, 32'h20, 6'd2));
      vecs.push_back(mk(32'h0, 1'b0, 1'b1, 5'd5, 32'h20, 6'd2));
      vecs.push_back(mk(32'h0, 1'b1, 1'b1, 5'd1, 32'h2, 6'd1));
      vecs.push_back(mk(32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 6'd0));
      // Extreme bits together: back-to-back grants 0 then 31.
      vecs.push_back(mk(32'h8000_0001, 1'b1, 1'b0, 5'd0, 32'h0, 6'd2));
      vecs.push_back(mk(32'h0, 1'b1, 1'b1, 5'd0, 32'h1, 6'd2));
      vecs.push_back(mk(32'h0, 1'b1, 1'b1, 5'd31, 32'h8000_0000, 6'd1));
      vecs.push_back(mk(32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 6'd0));
      // Multi-hot burst with consumer always ready.
      vecs.push_back(mk(32'h0000_0182, 1'b1, 1'b0, 5'd0, 32'h0, 6'd3));
      vecs.push_back(mk(32'h0, 1'b1, 1'b1, 5'd1, 32'h2, 6'd3));
      vecs.push_back(mk(32'h0, 1'b1, 1'b1, 5'd7, 32'h80, 6'd2));
      vecs.push_back(mk(32'h0, 1'b1, 1'b1, 5'd8, 32'h100, 6'd1));
      vecs.push_back(mk(32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 6'd0));

      #2;
      check_outputs("reset", 1'b0, 5'd0, 32'h0, 6'd0, 1'b1);
      @(negedge clk);
      async_reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].req, vecs[i].rdy);
         check_outputs($sformatf("vec%0d", i), vecs[i].valid, vecs[i].idx,
                       vecs[i].onehot, vecs[i].count, vecs[i].valid);
      end

      // Re-request of the sole offered bit during its handshake.
      step(32'h0000_0008, 1'b0);
      check_outputs("rereq.latch", 1'b0, 5'd0, 32'h0, 6'd1, 1'b0);
      step(32'h0, 1'b0);
      check_outputs("rereq.offer", 1'b1, 5'd3, 32'h8, 6'd1, 1'b1);
      step(32'h0000_0008, 1'b1);
      check_outputs("rereq.gap", 1'b0, 5'd0, 32'h0, 6'd1, 1'b0);
      step(32'h0, 1'b0);
      check_outputs("rereq.again", 1'b1, 5'd3, 32'h8, 6'd1, 1'b1);
      step(32'h0, 1'b1);
      check_outputs("rereq.drain", 1'b0, 5'd0, 32'h0, 6'd0, 1'b0);

      // Asynchronous reset in the middle of an offer, between clock edges.
      step(32'h0000_0024, 1'b0);
      step(32'h0, 1'b0);
      check_outputs("arst.pre", 1'b1, 5'd2, 32'h4, 6'd2, 1'b1);
      step(32'h0, 1'b0);
      #2;
      async_reset = 1'b0;
      #1;
      check_outputs("arst.now", 1'b0, 5'd0, 32'h0, 6'd0, 1'b1);
      @(negedge clk);
      async_reset = 1'b1;
      step(32'h0, 1'b0);
      check_outputs("arst.after1", 1'b0, 5'd0, 32'h0, 6'd0, 1'b1);
      step(32'h0, 1'b1);
      check_outputs("arst.after2", 1'b0, 5'd0, 32'h0, 6'd0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_pending_req_encoder
